// File: rtl/aead_pkg.sv
// ============================================================================
// Module  : aead_pkg
// Brief   : Shared types and constants for the AEAD block packer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package aead_pkg;

    localparam int AEAD_BLK_BYTES = 16;
    localparam int AEAD_LEN_W     = 64;
    localparam int AEAD_BLK_W     = AEAD_BLK_BYTES * 8;
    localparam int AEAD_IDX_W     = $clog2(AEAD_BLK_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AAD  = 2'd1,
        ST_CT   = 2'd2,
        ST_LEN  = 2'd3
    } pack_state_t;

    // Little-endian byte insert: byte idx lands at bits [8*idx+7 : 8*idx].
    function automatic logic [AEAD_BLK_W-1:0] put_byte(
        input logic [AEAD_BLK_W-1:0] blk,
        input logic [AEAD_IDX_W-1:0] idx,
        input logic [7:0]            b
    );
        logic [AEAD_BLK_W-1:0] r;
        r = blk;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aead_block_packer.sv
// ============================================================================
// Module  : aead_block_packer
// Brief   : Packs an AAD + ciphertext byte stream into zero-padded 128-bit
//           blocks followed by a {ct_len, aad_len} length block.
//           Optional macro PACKER_LEN_CHECK_EN enables the in_last check (err).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module aead_block_packer
    import aead_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [63:0]  aad_len,
    input  logic [63:0]  ct_len,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [127:0] blk_data,
    output logic         blk_final,
    output logic         busy,
    output logic         done,
    output logic         err
);

    pack_state_t             r_state;
    logic [AEAD_LEN_W-1:0]   r_aad_len;
    logic [AEAD_LEN_W-1:0]   r_ct_len;
    logic [AEAD_LEN_W-1:0]   r_rem;
    logic [AEAD_BLK_W-1:0]   r_asm;
    logic [AEAD_IDX_W-1:0]   r_idx;
    logic [AEAD_BLK_W-1:0]   r_blk_data;
    logic                    r_blk_valid;
    logic                    r_blk_final;
    logic                    r_done;

    logic                    w_in_ready;
    logic                    w_acc;
    logic                    w_sec_last;
    logic                    w_flush;
    logic                    w_hs;
    logic [AEAD_BLK_W-1:0]   w_asm_next;

    assign w_in_ready = ((r_state == ST_AAD) || (r_state == ST_CT)) && !r_blk_valid;
    assign w_acc      = in_valid && w_in_ready;
    assign w_sec_last = (r_rem == {{(AEAD_LEN_W-1){1'b0}}, 1'b1});
    assign w_flush    = (r_idx == AEAD_IDX_W'(AEAD_BLK_BYTES - 1)) || w_sec_last;
    assign w_hs       = r_blk_valid && blk_ready;
    assign w_asm_next = put_byte(r_asm, r_idx, in_data);

`ifdef PACKER_LEN_CHECK_EN
    logic r_err;
    logic w_msg_last;

    // The message ends on the last CT byte, or on the last AAD byte if there is no CT.
    assign w_msg_last = w_sec_last && ((r_state == ST_CT) || (r_ct_len == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_err <= 1'b0;
        end else if (w_acc && (in_last != w_msg_last)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_in_last;
    assign w_unused_in_last = in_last;
    assign err              = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_aad_len   <= '0;
            r_ct_len    <= '0;
            r_rem       <= '0;
            r_asm       <= '0;
            r_idx       <= '0;
            r_blk_data  <= '0;
            r_blk_valid <= 1'b0;
            r_blk_final <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_hs) begin
                r_blk_valid <= 1'b0;
                r_blk_final <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_aad_len <= aad_len;
                        r_ct_len  <= ct_len;
                        r_asm     <= '0;
                        r_idx     <= '0;
                        if (aad_len != '0) begin
                            r_state <= ST_AAD;
                            r_rem   <= aad_len;
                        end else if (ct_len != '0) begin
                            r_state <= ST_CT;
                            r_rem   <= ct_len;
                        end else begin
                            r_state <= ST_LEN;
                            r_rem   <= '0;
                        end
                    end
                end

                ST_AAD, ST_CT: begin
                    if (w_acc) begin
                        r_rem <= r_rem - {{(AEAD_LEN_W-1){1'b0}}, 1'b1};
                        if (w_flush) begin
                            r_blk_data  <= w_asm_next;
                            r_blk_valid <= 1'b1;
                            r_blk_final <= 1'b0;
                            r_asm       <= '0;
                            r_idx       <= '0;
                        end else begin
                            r_asm <= w_asm_next;
                            r_idx <= r_idx + AEAD_IDX_W'(1);
                        end
                        if (w_sec_last) begin
                            if ((r_state == ST_AAD) && (r_ct_len != '0)) begin
                                r_state <= ST_CT;
                                r_rem   <= r_ct_len;
                            end else begin
                                r_state <= ST_LEN;
                            end
                        end
                    end
                end

                ST_LEN: begin
                    // A trailing data block may still be pending; the length block waits for it.
                    if (!r_blk_valid) begin
                        r_blk_data  <= {r_ct_len, r_aad_len};
                        r_blk_valid <= 1'b1;
                        r_blk_final <= 1'b1;
                    end else if (w_hs && r_blk_final) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign blk_valid = r_blk_valid;
    assign blk_data  = r_blk_data;
    assign blk_final = r_blk_final;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;

endmodule

`default_nettype wire

// File: doc/aead_block_packer.md
AEAD_BLOCK_PACKER -- requirements
Module: aead_block_packer

Interface
REQ-001 clk  input  1  sole clock; all state on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle pulse; latches aad_len/ct_len; honoured only in IDLE.
REQ-004 aad_len  input  64  AAD length in bytes.
REQ-005 ct_len  input  64  ciphertext length in bytes.
REQ-006 in_valid / in_ready  input / output  1 / 1  byte-stream handshake; AAD bytes first, then ciphertext bytes.
REQ-007 in_data  input  8  message byte.
REQ-008 in_last  input  1  marks final ciphertext byte (or final AAD byte when ct_len=0).
REQ-009 blk_valid / blk_ready  output / input  1 / 1  128-bit block handshake toward chacha20_poly1305_core.
REQ-010 blk_data  output  128  block, little-endian: byte i at bits [8i+7:8i].
REQ-011 blk_final  output  1  high with the length block only.
REQ-012 busy  output  1  high in any state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the final block handshake.
REQ-014 err  output  1  sticky length-mismatch flag; cleared by start.

Function
REQ-015 States: IDLE, AAD, CT, LEN; start -> AAD if aad_len!=0, else CT if ct_len!=0, else LEN.
REQ-016 in_ready SHALL be high only in AAD or CT while blk_valid is low.
REQ-017 Each accepted byte SHALL be written at the current byte index (0..15) of a zero-initialised assembly register; 64-bit section-remaining counter decrements per byte.
REQ-018 When byte index 15 is accepted or the section's last byte is accepted, the assembly register (unfilled bytes zero) SHALL load into the output register, with blk_valid high the next cycle; the assembly register and index clear.
REQ-019 Section lengths that are multiples of 16 produce no extra pad block; a zero-length section produces no blocks.
REQ-020 After the last AAD byte, the state SHALL go to CT (ct_len!=0) or LEN; after the last CT byte, to LEN.
REQ-021 In LEN, when blk_valid is low, the output register SHALL load {ct_len, aad_len} (aad_len in bits [63:0]) with blk_final=1.
REQ-022 blk_data/blk_final SHALL hold stable while blk_valid && !blk_ready; blk_valid drops the cycle after handshake unless a new block loads the same cycle.
REQ-023 The blk_final handshake SHALL return the state to IDLE and pulse done the next cycle.
REQ-024 start while busy SHALL be ignored; no latched value changes.
REQ-025 in_valid outside AAD/CT SHALL be ignored (in_ready low).

Reset
REQ-026 On reset_n low: state IDLE; in_ready, blk_valid, blk_final, busy, done, err = 0; blk_data, counters, and assembly register = 0.
REQ-027 Reset mid-message SHALL abandon the message without emitting a partial or length block.

Configuration
REQ-028 With PACKER_LEN_CHECK_EN defined: err SHALL set when in_last is accepted with a byte that is not the final byte of the message, or when the final byte is accepted without in_last; packing continues per declared lengths.
REQ-029 Without PACKER_LEN_CHECK_EN: err SHALL be tied to 0 and in_last is ignored.

Structure
REQ-030 A shared package (aead_pkg) SHALL hold the state enum, AEAD_BLK_BYTES=16, and the length-width constant 64.
REQ-031 No sub-module; single FSM plus datapath.

Verification
REQ-032 aad_len=0, ct_len=16, bytes 0x00..0x0F, blk_ready=1 -> block 0x0F0E..0100, then length block with blk_data[127:64]=16, [63:0]=0, blk_final=1, done pulse.
REQ-033 aad_len=12, ct_len=3 -> AAD block with bytes 12..15 zero; CT block with bytes 3..15 zero; length block {3,12}; exactly 3 blocks.
REQ-034 aad_len=0, ct_len=0, start -> single length block of all zeros with blk_final=1, then done.
REQ-035 blk_ready held low for 5 cycles on the first block -> blk_data stable, in_ready low throughout, no byte lost.
REQ-036 PACKER_LEN_CHECK_EN, ct_len=5, in_last on byte 3 -> err=1 and stays 1 until next start; blocks unchanged.
REQ-037 reset_n low after 7 of 20 bytes -> all outputs at reset values; a new start packs a fresh message correctly.
